// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: shared ID/EX pipeline types and default widths
package operand_fetch_stage_pkg;
  localparam int DEF_ADDR = 5;
  localparam int DEF_BUS_W = 32;
  typedef struct packed {
    logic [DEF_BUS_W-1:0] op_a;
    logic [DEF_BUS_W-1:0] op_b;
    logic [DEF_BUS_W-1:0] store_data;
    logic [DEF_ADDR-1:0] rd_addr;
    logic reg_write;
    logic mem_read;
  } idex_t;
  typedef enum logic [1:0] {FWD_RF, FWD_WB, FWD_MEM} fwd_sel_t;
endpackage

// File: rtl/operand_fetch_stage_forward_mux.sv
// forward_mux: single-operand bypass selector, MEM over WB over register file
module forward_mux
  import operand_fetch_stage_pkg::*;
#(
  parameter int ADDR = DEF_ADDR,
  parameter int BUS_W = DEF_BUS_W
) (
  input  logic [ADDR-1:0]  src,
  input  logic [ADDR-1:0]  mem_rd_addr,
  input  logic             mem_reg_write,
  input  logic [BUS_W-1:0] mem_result,
  input  logic [ADDR-1:0]  wb_rd_addr,
  input  logic             wb_reg_write,
  input  logic [BUS_W-1:0] wb_data,
  input  logic [BUS_W-1:0] rf_data,
  output logic [BUS_W-1:0] value,
  output fwd_sel_t         sel
);
  always_comb begin
    sel = (src == '0) ? FWD_RF :
          (mem_reg_write && mem_rd_addr == src) ? FWD_MEM :
          (wb_reg_write && wb_rd_addr == src) ? FWD_WB : FWD_RF;
    value = (src == '0) ? '0 :
            (sel == FWD_MEM) ? mem_result :
            (sel == FWD_WB) ? wb_data : rf_data;
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: ID/EX operand fetch with MEM/WB forwarding and load-use stall
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int ADDR = DEF_ADDR,
  parameter int BUS_W = DEF_BUS_W
) (
  input  logic             reset,
  input  logic             reloj,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADDR-1:0]  in_rs_addr,
  input  logic [ADDR-1:0]  in_rt_addr,
  input  logic [ADDR-1:0]  in_rd_addr,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic             in_use_imm,
  input  logic [BUS_W-1:0] in_imm,
  output logic [ADDR-1:0]  rs_addr,
  output logic [ADDR-1:0]  rt_addr,
  input  logic [BUS_W-1:0] rs_data,
  input  logic [BUS_W-1:0] rt_data,
  input  logic [ADDR-1:0]  mem_rd_addr,
  input  logic             mem_reg_write,
  input  logic [BUS_W-1:0] mem_result,
  input  logic [ADDR-1:0]  wb_rd_addr,
  input  logic             wb_reg_write,
  input  logic [BUS_W-1:0] wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_op_a,
  output logic [BUS_W-1:0] out_op_b,
  output logic [BUS_W-1:0] out_store_data,
  output logic [ADDR-1:0]  out_rd_addr,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic [15:0]      stall_count
);
  idex_t r;
  logic hazard, advance;
  logic [BUS_W-1:0] a_val, b_val;
  fwd_sel_t a_sel, b_sel;
  assign rs_addr = in_rs_addr;
  assign rt_addr = in_rt_addr;
  forward_mux #(.ADDR(ADDR), .BUS_W(BUS_W)) fwd_a (
    .src(in_rs_addr), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .rf_data(rs_data), .value(a_val), .sel(a_sel)
  );
  forward_mux #(.ADDR(ADDR), .BUS_W(BUS_W)) fwd_b (
    .src(in_rt_addr), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .rf_data(rt_data), .value(b_val), .sel(b_sel)
  );
  // a load still in ID/EX cannot be bypassed yet; its consumer waits one bubble
  assign hazard = in_valid && out_valid && r.mem_read && r.rd_addr != '0 &&
                  (r.rd_addr == in_rs_addr || (r.rd_addr == in_rt_addr && !in_use_imm));
  assign advance = !out_valid || out_ready;
  assign in_ready = advance && !hazard && !flush;
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      r <= '0;
      stall_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid && !hazard;
      if (hazard) stall_count <= (&stall_count) ? stall_count : stall_count + 16'd1;
      else if (in_valid) r <= '{op_a: a_val, op_b: in_use_imm ? in_imm : b_val,
                                store_data: b_val, rd_addr: in_rd_addr,
                                reg_write: in_reg_write, mem_read: in_mem_read};
    end
  end
  assign out_op_a = r.op_a;
  assign out_op_b = r.op_b;
  assign out_store_data = r.store_data;
  assign out_rd_addr = r.rd_addr;
  assign out_reg_write = r.reg_write;
  assign out_mem_read = r.mem_read;
  a_zero_rf: assert property (@(posedge reloj) disable iff (reset) in_rs_addr == '0 |-> a_sel == FWD_RF);
  b_zero_rf: assert property (@(posedge reloj) disable iff (reset) in_rt_addr == '0 |-> b_sel == FWD_RF);
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- ID/EX operand stage sitting directly downstream of register_file.
- Drives the register file read addresses from the decoded instruction and consumes rs_data/rt_data.
- Resolves RAW hazards by forwarding from MEM and WB, and by stalling on load-use.
- Registers the selected operands into the ID/EX pipeline register with a valid/ready handshake on both sides.

Parameters:
ADDR, 5, register address width
BUS_W, 32, datapath width

Ports:
reset  in  1  asynchronous, active-high; clears all state
reloj  in  1  clock, rising edge
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_rs_addr  in  ADDR  source A register
in_rt_addr  in  ADDR  source B register
in_rd_addr  in  ADDR  destination register
in_reg_write  in  1  instruction writes rd
in_mem_read  in  1  instruction is a load
in_use_imm  in  1  operand B comes from in_imm
in_imm  in  BUS_W  sign-extended immediate
rs_addr  out  ADDR  to register_file, equals in_rs_addr (combinational)
rt_addr  out  ADDR  to register_file, equals in_rt_addr (combinational)
rs_data  in  BUS_W  from register_file
rt_data  in  BUS_W  from register_file
mem_rd_addr  in  ADDR  MEM-stage destination
mem_reg_write  in  1  MEM-stage writes rd
mem_result  in  BUS_W  MEM-stage ALU result
wb_rd_addr  in  ADDR  WB destination (same as register_file rd_addr)
wb_reg_write  in  1  WB write enable
wb_data  in  BUS_W  WB data
flush  in  1  squash stage contents (branch/exception)
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  EX accepts this cycle
out_op_a  out  BUS_W  operand A
out_op_b  out  BUS_W  operand B (immediate or register)
out_store_data  out  BUS_W  forwarded rt value
out_rd_addr  out  ADDR  destination
out_reg_write  out  1  writes rd
out_mem_read  out  1  is a load
stall_count  out  16  saturating count of load-use stall cycles

Behaviour:
- Reset: out_valid=0; all out_* data, addresses and flags=0; stall_count=0. Reset is asynchronous and is honoured mid-operation; an in-flight instruction is discarded.
- Forwarding, per source (rs, rt), priority MEM > WB > register file:
  - MEM selected when mem_reg_write && mem_rd_addr==src && src!=0.
  - WB selected when wb_reg_write && wb_rd_addr==src && src!=0. WB bypass is mandatory because register_file writes on the same edge.
  - src==0 always yields 0, regardless of forwarding inputs.
- out_op_b = in_use_imm ? in_imm : forwarded rt. out_store_data = forwarded rt always.
- Load-use hazard: hazard = out_valid && out_mem_read && out_rd_addr!=0 && (out_rd_addr==in_rs_addr || (out_rd_addr==in_rt_addr && !in_use_imm)) && in_valid.
- Handshake: advance = !out_valid || out_ready; in_ready = advance && !hazard && !flush.
- Per-cycle update, in priority order:
  - flush=1: out_valid<=0; input not accepted.
  - advance && hazard: bubble inserted (out_valid<=0), in_* held by upstream, stall_count+1 saturating at 16'hFFFF.
  - advance && in_valid: capture all outputs, out_valid<=1.
  - advance && !in_valid: out_valid<=0.
  - !advance: hold all outputs unchanged.
- Latency: one cycle from accepted input to out_valid.
- A stall lasts exactly one cycle: after the bubble the load is in MEM and is covered by forwarding from the memory-data path downstream.
- Simultaneous flush and hazard: flush wins and stall_count does not increment.
- While out_valid=1 and out_ready=0, outputs are stable (no forwarding re-evaluation).

Decomposition:
- Shared pipeline package holds:
  - ADDR/BUS_W defaults
  - typedef struct idex_t {op_a, op_b, store_data, rd_addr, reg_write, mem_read}
  - typedef enum fwd_sel_t {FWD_RF, FWD_WB, FWD_MEM}
- One sub-module, forward_mux: a single-operand forwarding selector (addresses, enables, data -> value, fwd_sel_t), instantiated twice.

Test Plan:
- Forward MEM: regfile r3=5, mem_rd_addr=3, mem_reg_write=1, mem_result=0x77, in_rs_addr=3 -> next cycle out_op_a=0x77.
- Dual hit: mem and wb both target r4 (0x11 / 0x22) -> out_op_b=0x11. With mem_reg_write=0 -> out_op_b=0x22. With in_rt_addr=0 -> out_op_b=0.
- Load-use: a load to r7 in the output register, next instruction reads r7 -> in_ready=0 for exactly one cycle, one bubble (out_valid=0), stall_count=1. Same sequence with in_use_imm=1 and only rt=r7 -> no stall.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged and in_ready=0. Release -> next instruction captured on the following edge.
- Flush during hazard: flush=1 while a load-use hazard is present -> out_valid=0 next cycle, stall_count unchanged.
- Reset mid-stream: assert reset asynchronously between edges while out_valid=1 -> out_valid and stall_count read 0 immediately, before the next clock edge.
